// File: rtl/tone_meter.sv
// tone_meter: measures period and high time of an external square wave in the CLOCK_50 domain.
// Optional input deglitch filter is enabled by defining TONE_METER_DEGLITCH_EN.
module tone_meter #(
    parameter int COUNTER_SIZE    = 32,
    parameter int TIMEOUT_CYCLES  = 100000000,
    parameter int DEGLITCH_CYCLES = 4
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET,
    input  logic                    TONE_IN,
    output logic [COUNTER_SIZE-1:0] PERIOD,
    output logic [COUNTER_SIZE-1:0] HIGH_TIME,
    output logic                    PERIOD_VALID,
    output logic                    TIMEOUT,
    output logic                    LOCKED,
    output logic                    LED
);

    localparam logic [COUNTER_SIZE-1:0] TIMEOUT_VAL = COUNTER_SIZE'(TIMEOUT_CYCLES);
    localparam logic [COUNTER_SIZE-1:0] CNT_ONE     = COUNTER_SIZE'(1);

    typedef enum logic {
        ST_IDLE,
        ST_MEASURE
    } state_t;

    if (DEGLITCH_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
        (COUNTER_SIZE < 32 && longint'(TIMEOUT_CYCLES) >= (longint'(1) << COUNTER_SIZE))) begin : g_badConfig
        $error("tone_meter: invalid parameter combination");
    end

    state_t r_state;
    state_t w_stateNext;

    logic r_s1;
    logic r_s2;
    logic r_fPrev;
    logic w_f;
    logic w_rise;

    logic [COUNTER_SIZE-1:0] r_pcnt;
    logic [COUNTER_SIZE-1:0] r_hcnt;
    logic [COUNTER_SIZE-1:0] r_period;
    logic [COUNTER_SIZE-1:0] r_highTime;
    logic                    r_periodValid;
    logic                    r_timeout;
    logic                    r_locked;

    logic [COUNTER_SIZE-1:0] w_pcntNext;
    logic [COUNTER_SIZE-1:0] w_hcntNext;
    logic [COUNTER_SIZE-1:0] w_periodNext;
    logic [COUNTER_SIZE-1:0] w_highTimeNext;
    logic                    w_periodValidNext;
    logic                    w_timeoutNext;
    logic                    w_lockedNext;

    // Two-flop synchronizer for the asynchronous tone line.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= TONE_IN;
            r_s2 <= r_s1;
        end
    end

`ifdef TONE_METER_DEGLITCH_EN
    localparam int              GW          = $clog2(DEGLITCH_CYCLES + 1);
    localparam logic [GW-1:0]   GLITCH_LAST = GW'(DEGLITCH_CYCLES - 1);
    localparam logic [GW-1:0]   GLITCH_ONE  = GW'(1);

    logic [GW-1:0] r_gcnt;
    logic          r_filt;

    // The filtered level follows s2 only after it has disagreed for DEGLITCH_CYCLES cycles in a row.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_filt <= 1'b0;
            r_gcnt <= '0;
        end else if (r_s2 != r_filt) begin
            if (r_gcnt == GLITCH_LAST) begin
                r_filt <= r_s2;
                r_gcnt <= '0;
            end else begin
                r_gcnt <= r_gcnt + GLITCH_ONE;
            end
        end else begin
            r_gcnt <= '0;
        end
    end

    assign w_f = r_filt;
`else
    assign w_f = r_s2;
`endif

    assign w_rise = w_f & ~r_fPrev;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_stateNext = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (!w_rise && r_pcnt == TIMEOUT_VAL) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // A rise arriving exactly at the timeout count still completes the measurement.
    always_comb begin
        w_pcntNext        = r_pcnt;
        w_hcntNext        = r_hcnt;
        w_periodNext      = r_period;
        w_highTimeNext    = r_highTime;
        w_periodValidNext = 1'b0;
        w_timeoutNext     = 1'b0;
        w_lockedNext      = r_locked;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_pcntNext = CNT_ONE;
                    w_hcntNext = CNT_ONE;
                end
            end
            ST_MEASURE: begin
                if (w_rise) begin
                    w_periodNext      = r_pcnt;
                    w_highTimeNext    = r_hcnt;
                    w_periodValidNext = 1'b1;
                    w_lockedNext      = 1'b1;
                    w_pcntNext        = CNT_ONE;
                    w_hcntNext        = CNT_ONE;
                end else if (r_pcnt == TIMEOUT_VAL) begin
                    w_timeoutNext = 1'b1;
                    w_lockedNext  = 1'b0;
                end else begin
                    w_pcntNext = r_pcnt + CNT_ONE;
                    if (w_f && r_hcnt != TIMEOUT_VAL) begin
                        w_hcntNext = r_hcnt + CNT_ONE;
                    end
                end
            end
            default: begin
                w_lockedNext = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_fPrev       <= 1'b0;
            r_pcnt        <= '0;
            r_hcnt        <= '0;
            r_period      <= '0;
            r_highTime    <= '0;
            r_periodValid <= 1'b0;
            r_timeout     <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_fPrev       <= w_f;
            r_pcnt        <= w_pcntNext;
            r_hcnt        <= w_hcntNext;
            r_period      <= w_periodNext;
            r_highTime    <= w_highTimeNext;
            r_periodValid <= w_periodValidNext;
            r_timeout     <= w_timeoutNext;
            r_locked      <= w_lockedNext;
        end
    end

    assign PERIOD       = r_period;
    assign HIGH_TIME    = r_highTime;
    assign PERIOD_VALID = r_periodValid;
    assign TIMEOUT      = r_timeout;
    assign LOCKED       = r_locked;
    assign LED          = r_locked;

endmodule

// File: tb/tb_tone_meter.sv
// tb_tone_meter: drives square waves into tone_meter and compares every cycle against a
// timestamp-based reference model of the measurement rules.
module tb_tone_meter;

    localparam int CS      = 32;
    localparam int TO_CYC  = 1000;
    localparam int DEG_CYC = 4;

    logic          clk = 1'b0;
    logic          RESET;
    logic          TONE_IN;
    logic [CS-1:0] PERIOD;
    logic [CS-1:0] HIGH_TIME;
    logic          PERIOD_VALID;
    logic          TIMEOUT;
    logic          LOCKED;
    logic          LED;

    always #5 clk = ~clk;

    tone_meter #(
        .COUNTER_SIZE   (CS),
        .TIMEOUT_CYCLES (TO_CYC),
        .DEGLITCH_CYCLES(DEG_CYC)
    ) dut (
        .CLOCK_50    (clk),
        .RESET       (RESET),
        .TONE_IN     (TONE_IN),
        .PERIOD      (PERIOD),
        .HIGH_TIME   (HIGH_TIME),
        .PERIOD_VALID(PERIOD_VALID),
        .TIMEOUT     (TIMEOUT),
        .LOCKED      (LOCKED),
        .LED         (LED)
    );

    int nVec = 0;
    int nMis = 0;

    // Reference model: edges are timestamps; period = difference of acted-on rise times.
    int          cyc       = 0;
    int          lastRise  = 0;
    int          highCount = 0;
    bit          armed     = 0;
    logic [31:0] mPeriod   = 0;
    logic [31:0] mHigh     = 0;
    bit          mPv       = 0;
    bit          mTo       = 0;
    bit          mLocked   = 0;
    bit          fNow      = 0;
    bit          fOld      = 0;
    bit          t1        = 0;
    bit          t2        = 0;
    int          run       = 0;

    logic [63:0] dutSig = 0;
    logic [63:0] mdlSig = 0;
    int dutPv = 0, dutTo = 0, mdlPv = 0, mdlTo = 0;
    int lastPvCyc = 0, prevPvCyc = 0, lastToCyc = 0;

    function automatic logic [63:0] mix(input logic [63:0] s, input logic [31:0] a,
                                        input logic [31:0] b, input logic [3:0] f);
        return ((s * 64'd1000003) ^ {a, b}) * 64'd31 + {60'd0, f};
    endfunction

    task automatic modelEdge(input bit tone, input bit rst);
        bit rise;
        bit fNext;
        cyc++;
        if (rst) begin
            armed = 0; mPeriod = 0; mHigh = 0; mPv = 0; mTo = 0; mLocked = 0;
            fNow = 0; fOld = 0; t1 = 0; t2 = 0; run = 0;
            return;
        end
        rise = fNow && !fOld;
        mPv  = 0;
        mTo  = 0;
        if (rise) begin
            if (armed) begin
                mPeriod = 32'(cyc - lastRise);
                mHigh   = 32'(highCount);
                mPv     = 1;
                mLocked = 1;
            end
            armed     = 1;
            lastRise  = cyc;
            highCount = 1;
        end else if (armed) begin
            if (cyc - lastRise == TO_CYC) begin
                mTo = 1; mLocked = 0; armed = 0;
            end else begin
                highCount += int'(fNow);
            end
        end
`ifdef TONE_METER_DEGLITCH_EN
        fNext = fNow;
        if (t2 != fNow) begin
            run++;
            if (run == DEG_CYC) begin
                fNext = t2;
                run   = 0;
            end
        end else begin
            run = 0;
        end
`else
        fNext = t1;
`endif
        fOld = fNow;
        fNow = fNext;
        t2   = t1;
        t1   = tone;
    endtask

    task automatic step(input bit tone, input bit rst);
        TONE_IN = tone;
        RESET   = rst;
        @(posedge clk);
        modelEdge(tone, rst);
        #1;
        dutSig = mix(dutSig, PERIOD, HIGH_TIME, {PERIOD_VALID, TIMEOUT, LOCKED, LED});
        mdlSig = mix(mdlSig, mPeriod, mHigh, {mPv, mTo, mLocked, mLocked});
        if (PERIOD_VALID === 1'b1) begin dutPv++; prevPvCyc = lastPvCyc; lastPvCyc = cyc; end
        if (TIMEOUT === 1'b1) begin dutTo++; lastToCyc = cyc; end
        if (mPv) mdlPv++;
        if (mTo) mdlTo++;
    endtask

    task automatic beginScenario();
        dutSig = 0; mdlSig = 0;
        dutPv = 0; dutTo = 0; mdlPv = 0; mdlTo = 0;
    endtask

    task automatic wave(input int period, input int high, input int n);
        for (int p = 0; p < n; p++)
            for (int c = 0; c < period; c++)
                step(c < high, 0);
    endtask

    task automatic lowFor(input int n);
        for (int i = 0; i < n; i++) step(0, 0);
    endtask

    task automatic test_reset();
        beginScenario();
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom_range(0, 1)), 1);
            nVec++;
            if ({PERIOD, HIGH_TIME, PERIOD_VALID, TIMEOUT, LOCKED, LED} !== '0) begin
                nMis++;
                $display("[TB] FAIL reset_outputs: got PERIOD=%0d HIGH=%0d flags=%b, expected all 0",
                         PERIOD, HIGH_TIME, {PERIOD_VALID, TIMEOUT, LOCKED, LED});
            end
        end
        nVec++;
        if (dutSig !== mdlSig) begin
            nMis++;
            $display("[TB] FAIL reset_trace: got sig %h, expected %h", dutSig, mdlSig);
        end
    endtask

    task automatic test_basic();
        beginScenario();
        lowFor(5);
        wave(100, 50, 6);
        nVec++;
        if (dutSig !== mdlSig) begin nMis++; $display("[TB] FAIL basic_trace: got sig %h, expected %h", dutSig, mdlSig); end
        nVec++;
        if (PERIOD !== 32'd100) begin nMis++; $display("[TB] FAIL basic_period: got %0d, expected 100", PERIOD); end
        nVec++;
        if (HIGH_TIME !== 32'd50) begin nMis++; $display("[TB] FAIL basic_high: got %0d, expected 50", HIGH_TIME); end
        nVec++;
        if ({LOCKED, LED} !== 2'b11) begin nMis++; $display("[TB] FAIL basic_locked: got %b, expected 11", {LOCKED, LED}); end
        nVec++;
        if (dutPv !== 5) begin nMis++; $display("[TB] FAIL basic_pv_count: got %0d, expected 5", dutPv); end
        nVec++;
        if (lastPvCyc - prevPvCyc !== 100) begin
            nMis++; $display("[TB] FAIL basic_pv_spacing: got %0d, expected 100", lastPvCyc - prevPvCyc);
        end
    endtask

    task automatic test_timeout();
        beginScenario();
        lowFor(1100);
        nVec++;
        if (dutSig !== mdlSig) begin nMis++; $display("[TB] FAIL timeout_trace: got sig %h, expected %h", dutSig, mdlSig); end
        nVec++;
        if (dutTo !== 1) begin nMis++; $display("[TB] FAIL timeout_count: got %0d, expected 1", dutTo); end
        nVec++;
        if (lastToCyc - lastPvCyc !== TO_CYC) begin
            nMis++; $display("[TB] FAIL timeout_delay: got %0d, expected %0d", lastToCyc - lastPvCyc, TO_CYC);
        end
        nVec++;
        if ({LOCKED, LED} !== 2'b00) begin nMis++; $display("[TB] FAIL timeout_locked: got %b, expected 00", {LOCKED, LED}); end
        nVec++;
        if (PERIOD !== 32'd100) begin nMis++; $display("[TB] FAIL timeout_period_hold: got %0d, expected 100", PERIOD); end
    endtask

    task automatic test_boundary();
        step(0, 1); step(0, 1); step(0, 1);
        beginScenario();
        wave(1000, 500, 3);
        wave(1001, 500, 3);
        lowFor(10);
        nVec++;
        if (dutSig !== mdlSig) begin nMis++; $display("[TB] FAIL boundary_trace: got sig %h, expected %h", dutSig, mdlSig); end
        nVec++;
        if (dutPv !== 3) begin nMis++; $display("[TB] FAIL boundary_pv_count: got %0d, expected 3", dutPv); end
        nVec++;
        if (dutTo !== 3) begin nMis++; $display("[TB] FAIL boundary_to_count: got %0d, expected 3", dutTo); end
        nVec++;
        if (PERIOD !== 32'd1000) begin nMis++; $display("[TB] FAIL boundary_period: got %0d, expected 1000", PERIOD); end
        nVec++;
        if (HIGH_TIME !== 32'd500) begin nMis++; $display("[TB] FAIL boundary_high: got %0d, expected 500", HIGH_TIME); end
    endtask

    task automatic test_reset_mid();
        int pvMark;
        step(0, 1); step(0, 1);
        beginScenario();
        wave(100, 30, 3);
        for (int c = 0; c < 100; c++) step(c < 30, c == 40);
        pvMark = dutPv;
        wave(100, 30, 1);
        nVec++;
        if (dutPv !== pvMark) begin nMis++; $display("[TB] FAIL resetmid_rearm: got %0d pulses, expected 0", dutPv - pvMark); end
        wave(100, 30, 1);
        nVec++;
        if (dutPv !== pvMark + 1) begin nMis++; $display("[TB] FAIL resetmid_next: got %0d pulses, expected 1", dutPv - pvMark); end
        nVec++;
        if (PERIOD !== 32'd100) begin nMis++; $display("[TB] FAIL resetmid_period: got %0d, expected 100", PERIOD); end
        nVec++;
        if (dutSig !== mdlSig) begin nMis++; $display("[TB] FAIL resetmid_trace: got sig %h, expected %h", dutSig, mdlSig); end
    endtask

    task automatic test_glitch();
        int expPv, expPer, expHigh;
`ifdef TONE_METER_DEGLITCH_EN
        expPv = 3; expPer = 100; expHigh = 20;
`else
        expPv = 7; expPer = 30; expHigh = 20;
`endif
        step(0, 1); step(0, 1);
        beginScenario();
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 100; c++)
                step((c < 20) || (c == 30) || (c == 31), 0);
        lowFor(10);
        nVec++;
        if (dutSig !== mdlSig) begin nMis++; $display("[TB] FAIL glitch_trace: got sig %h, expected %h", dutSig, mdlSig); end
        nVec++;
        if (dutPv !== expPv) begin nMis++; $display("[TB] FAIL glitch_pv_count: got %0d, expected %0d", dutPv, expPv); end
        nVec++;
        if (PERIOD !== 32'(expPer)) begin nMis++; $display("[TB] FAIL glitch_period: got %0d, expected %0d", PERIOD, expPer); end
        nVec++;
        if (HIGH_TIME !== 32'(expHigh)) begin nMis++; $display("[TB] FAIL glitch_high: got %0d, expected %0d", HIGH_TIME, expHigh); end
    endtask

    task automatic test_random();
        int per, hi;
        step(0, 1); step(0, 1);
        beginScenario();
        for (int k = 0; k < 10; k++) begin
            per = int'($urandom_range(20, 400));
            hi  = int'($urandom_range(5, per - 5));
            wave(per, hi, int'($urandom_range(1, 3)));
            if ($urandom_range(0, 3) == 0) lowFor(int'($urandom_range(900, 1100)));
        end
        lowFor(5);
        nVec++;
        if (dutSig !== mdlSig) begin nMis++; $display("[TB] FAIL random_trace: got sig %h, expected %h", dutSig, mdlSig); end
        nVec++;
        if (dutPv !== mdlPv) begin nMis++; $display("[TB] FAIL random_pv_count: got %0d, expected %0d", dutPv, mdlPv); end
        nVec++;
        if (dutTo !== mdlTo) begin nMis++; $display("[TB] FAIL random_to_count: got %0d, expected %0d", dutTo, mdlTo); end
        nVec++;
        if (PERIOD !== mPeriod) begin nMis++; $display("[TB] FAIL random_period: got %0d, expected %0d", PERIOD, mPeriod); end
    endtask

    initial begin
        RESET   = 1'b1;
        TONE_IN = 1'b0;
        test_reset();
        test_basic();
        test_timeout();
        test_boundary();
        test_reset_mid();
        test_glitch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/tone_meter.md
Name: tone_meter

Overview:
- Receive-side counterpart of the musicbox square-wave tone generator.
- Samples an external square wave (a tone line or a looped-back SPEAKER pin) in the CLOCK_50 domain.
- Measures its period and high time in clock cycles, and reports lock and loss-of-signal.
- Used for self-test of tone dividers and for pitch readback on the DE0-Nano.

Parameters:
- COUNTER_SIZE, 32: width of PERIOD, HIGH_TIME and the internal counters.
- TIMEOUT_CYCLES, 100000000: cycles without a rising edge before signal loss is declared (2 s at 50 MHz). Must be < 2^COUNTER_SIZE.
- DEGLITCH_CYCLES, 4: filter length, used only when TONE_METER_DEGLITCH_EN is defined. Must be >= 1.

Ports:
- CLOCK_50, input, 1: system clock.
- RESET, input, 1: synchronous, active-high reset.
- TONE_IN, input, 1: asynchronous square-wave input.
- PERIOD, output, COUNTER_SIZE: last measured period in CLOCK_50 cycles.
- HIGH_TIME, output, COUNTER_SIZE: high cycles within the last measured period.
- PERIOD_VALID, output, 1: one-cycle pulse when PERIOD and HIGH_TIME update.
- TIMEOUT, output, 1: one-cycle pulse on loss of signal.
- LOCKED, output, 1: high while periodic edges are being received.
- LED, output, 1: equals LOCKED.

Behaviour:
- All state is clocked on posedge CLOCK_50. RESET is synchronous, active-high and overrides everything.
- Reset values:
  - All outputs 0.
  - Synchronizer flops, edge-history flop and counters 0.
  - FSM in IDLE.
- Input path: TONE_IN passes through two flops (s1, s2). A third flop holds the previous filtered value.
- Filtered signal: f = s2, or the filter output when the optional feature is enabled.
- Edge detect: rise = f & ~f_prev, combinational.
- Latency: if TONE_IN is first sampled high at edge k, rise is true in the cycle after edge k+1 and acted on at edge k+2 (no deglitch).
- Counters:
  - pcnt: period counter, saturates at TIMEOUT_CYCLES.
  - hcnt: high-time counter, saturates at TIMEOUT_CYCLES.
- FSM:
  - IDLE: waiting for a first edge. On rise: pcnt <= 1, hcnt <= 1, go to MEASURE. No PERIOD_VALID on this first edge.
  - MEASURE, no rise and pcnt < TIMEOUT_CYCLES: pcnt <= pcnt + 1. hcnt <= hcnt + 1 when f = 1, otherwise hcnt holds.
  - MEASURE, rise: PERIOD <= pcnt, HIGH_TIME <= hcnt, PERIOD_VALID <= 1 for one cycle, LOCKED <= 1, pcnt <= 1, hcnt <= 1, stay in MEASURE.
  - MEASURE, no rise and pcnt == TIMEOUT_CYCLES: TIMEOUT <= 1 for one cycle, LOCKED <= 0, go to IDLE. PERIOD and HIGH_TIME hold their last values.
- Resulting values for an ideal input of period P cycles:
  - PERIOD = P.
  - HIGH_TIME = number of cycles f was high, counting the rise cycle.
  - 50% duty with even P gives HIGH_TIME = P/2.
- Rise and pcnt == TIMEOUT_CYCLES in the same cycle: rise wins. PERIOD = TIMEOUT_CYCLES, no TIMEOUT pulse.
- PERIOD_VALID and TIMEOUT are never high in the same cycle.
- PERIOD and HIGH_TIME change only with PERIOD_VALID or RESET.
- Constant-high or constant-low input: no rise occurs, so TIMEOUT fires once and the FSM stays in IDLE.
- RESET mid-measurement: partial count discarded, FSM to IDLE. The next rising edge only re-arms and produces no PERIOD_VALID.
- Edges faster than the synchronizer can resolve (< 2 cycles per level) are not guaranteed to be measured.

Optional Feature:
- Macro: TONE_METER_DEGLITCH_EN.
- Defined:
  - A filter sits between s2 and f, with counter gcnt, width ceil(log2(DEGLITCH_CYCLES+1)).
  - While s2 != f, gcnt increments. When gcnt reaches DEGLITCH_CYCLES - 1 and s2 still differs, f <= s2 and gcnt <= 0.
  - Any cycle with s2 == f clears gcnt.
  - Pulses shorter than DEGLITCH_CYCLES cycles are ignored.
  - Edge latency grows by DEGLITCH_CYCLES cycles; measured PERIOD is unchanged for clean input.
  - Reset value of f and gcnt is 0.
- Not defined: f = s2 directly. No filter logic; the DEGLITCH_CYCLES parameter is ignored.

Test Plan:
1. Reset check: assert RESET 3 cycles with TONE_IN toggling -> PERIOD = 0, HIGH_TIME = 0, PERIOD_VALID, TIMEOUT, LOCKED and LED all 0; FSM idle.
2. Basic measurement (TIMEOUT_CYCLES = 1000): square wave, period 100, 50% duty -> first PERIOD_VALID at the 2nd rising edge; then PERIOD = 100, HIGH_TIME = 50; PERIOD_VALID pulses every 100 cycles; LOCKED = LED = 1.
3. Loss of signal (TIMEOUT_CYCLES = 1000): lock on period 100, then hold TONE_IN low -> single TIMEOUT pulse 1000 cycles after the last rise is acted on; LOCKED = 0; PERIOD still 100.
4. Boundary: period exactly 1000 with TIMEOUT_CYCLES = 1000 -> PERIOD = 1000, no TIMEOUT pulse. Period 1001 -> TIMEOUT fires and the next edge only re-arms.
5. Reset mid-operation: assert RESET 40 cycles into a period-100 measurement, then one rising edge -> no PERIOD_VALID. The following edge, 100 cycles later, gives PERIOD = 100.
6. Glitch (DEGLITCH_CYCLES = 4): a 2-cycle high pulse 30 cycles into a period-100, 20%-duty wave.
   - Macro defined: pulse ignored; PERIOD = 100, HIGH_TIME = 20.
   - Macro undefined: extra PERIOD_VALID with PERIOD = 30.
